vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Produces the pixel coordinates (x, y) that feed the game graphics block.
- Accepts the RGB value that block returns for the current pixel.
- Drives the VGA connector: hsync, vsync and blanked, registered rgb.
- Fixed 640x480@60 timing by default, all timing parameterised; pixel rate derived from clk via integer divider.

Parameters:
- CLK_DIV, 2: clk cycles per pixel (min 1).
- H_DISPLAY, 640: visible columns.
- H_FRONT, 16: horizontal front porch, pixels.
- H_SYNC, 96: hsync pulse width, pixels.
- H_BACK, 48: horizontal back porch, pixels.
- V_DISPLAY, 480: visible lines.
- V_FRONT, 10: vertical front porch, lines.
- V_SYNC, 2: vsync pulse width, lines.
- V_BACK, 33: vertical back porch, lines.
- HS_POL, 0: active level of hsync.
- VS_POL, 0: active level of vsync.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rgb_in  in  3  pixel colour for current (x, y), from graphics block
- x  out  10  current column counter
- y  out  10  current line counter
- p_tick  out  1  one-clk pixel-enable strobe
- frame_tick  out  1  one-clk pulse at end of frame
- video_on  out  1  pipelined visible-area flag
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- rgb_out  out  3  registered, blanked colour to DAC

Behaviour:
- rst: one clock; reset is asynchronous and active-low.
- Reset values: div_cnt=0, x=0, y=0, p_tick=0, frame_tick=0, video_on=0, rgb_out=0, hsync=~HS_POL, vsync=~VS_POL.
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. p_tick=1 for exactly the clk where div_cnt==CLK_DIV-1. CLK_DIV=1 gives p_tick constantly high after reset release.
- Counters, updated only on p_tick:
  - x increments; x==H_TOTAL-1 wraps to 0.
  - y increments only when x wraps; y==V_TOTAL-1 with x wrap sends y to 0.
  - x, y are counter registers, driven directly with no extra delay.
- frame_tick: 1 on the clk where p_tick=1, x==H_TOTAL-1 and y==V_TOTAL-1; otherwise 0.
- Pipeline stage, registered on p_tick, 1 pixel latency from x/y:
  - video_on <= (x<H_DISPLAY && y<V_DISPLAY).
  - hsync <= HS_POL when H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751), else ~HS_POL.
  - vsync <= VS_POL when V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491), else ~VS_POL.
  - rgb_out <= visible ? rgb_in : 3'b000, sampling rgb_in in the same clk as p_tick.
  - Keeps rgb, hsync and vsync mutually aligned.
- Between p_ticks, all pipeline outputs hold.
- Counter widths: 10 bits, compare on full width; no counter reaches 1024 with defaults.
- Reset mid-frame: all state returns to reset values immediately. Counting restarts at (0,0) with the first p_tick after deassert, on the CLK_DIV-th clk.

Optional Feature:
- Macro VGA_RGB_BORDER_EN.
- Defined:
  - visible pixels with x==0, x==H_DISPLAY-1, y==0 or y==V_DISPLAY-1 output rgb_out=3'b111, ignoring rgb_in.
  - Same one-pixel latency and blanking rules apply.
  - Used for monitor alignment.
- Undefined: rgb_out follows rgb_in in the visible area exactly as above.

Test Plan:
- Release rst, CLK_DIV=2, run one frame → p_tick period 2 clk; frame_tick period exactly 840000 clk; x max 799; y max 524.
- Observe one line → hsync low for exactly 96 pixels, starting the p_tick after x==656; video_on high for exactly 640 consecutive pixels per visible line.
- Observe vsync → low for exactly 2 lines, starting the line after y==490; video_on stays 0 for all of lines 480..524.
- Hold rgb_in=3'b101 → rgb_out=3'b101 only while video_on=1; rgb_out=3'b000 during porches and sync.
- Assert rst asynchronously at x=300, y=200 → outputs take reset values without a clk edge; after release, x=0, y=0 and the first x increment occurs 2 clk later.
- With VGA_RGB_BORDER_EN defined and rgb_in=3'b001 → rgb_out=3'b111 at pixels (0,5), (639,5), (5,0), (5,479); rgb_out=3'b001 at (5,5).

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with pixel-rate divider and a
// registered sync/colour stage. Define VGA_RGB_BORDER_EN for a white border.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       p_tick,
    output logic       frame_tick,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HD       = 10'(H_DISPLAY);
    localparam logic [9:0] VD       = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic       HS_ACT   = HS_POL[0];
    localparam logic       VS_ACT   = VS_POL[0];

    logic [DIV_W-1:0] div_cnt;
    logic             x_last;
    logic             y_last;
    logic             visible;
    logic             hs_act;
    logic             vs_act;
    logic [2:0]       rgb_next;

    // Pixel-rate divider: wraps every CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Strobes; gated by rst so they read 0 while reset is held.
    always_comb begin
        x_last     = (x == X_LAST);
        y_last     = (y == Y_LAST);
        p_tick     = rst && (div_cnt == DIV_LAST);
        frame_tick = p_tick && x_last && y_last;
    end

    // Raster position counters, advanced once per pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (p_tick) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 10'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    // Decode visibility, sync windows and colour for the current pixel.
    always_comb begin
        visible  = (x < HD) && (y < VD);
        hs_act   = (x >= HS_START) && (x <= HS_END);
        vs_act   = (y >= VS_START) && (y <= VS_END);
        rgb_next = 3'b000;
        if (visible) begin
`ifdef VGA_RGB_BORDER_EN
            if ((x == '0) || (x == HD - 10'd1) ||
                (y == '0) || (y == VD - 10'd1)) begin
                rgb_next = 3'b111;
            end else begin
                rgb_next = rgb_in;
            end
`else
            rgb_next = rgb_in;
`endif
        end
    end

    // One-pixel output stage keeps colour and both syncs aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            video_on <= 1'b0;
            hsync    <= ~HS_ACT;
            vsync    <= ~VS_ACT;
            rgb_out  <= 3'b000;
        end else if (p_tick) begin
            video_on <= visible;
            hsync    <= hs_act ? HS_ACT : ~HS_ACT;
            vsync    <= vs_act ? VS_ACT : ~VS_ACT;
            rgb_out  <= rgb_next;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen on a reduced raster
// (30x19 total, 16x12 visible) so full frames stay short.
module tb_vga_sync_gen;

    localparam int CLK_DIV = 2;
    localparam int HD = 16, HF = 4, HS = 6, HB = 4;
    localparam int VD = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] rgb_in = 3'b101;
    logic [9:0] x;
    logic [9:0] y;
    logic       p_tick;
    logic       frame_tick;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb_out;

    int checks = 0;
    int fails  = 0;

    vga_sync_gen #(
        .CLK_DIV(CLK_DIV),
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(0), .VS_POL(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rgb_in(rgb_in),
        .x(x),
        .y(y),
        .p_tick(p_tick),
        .frame_tick(frame_tick),
        .video_on(video_on),
        .hsync(hsync),
        .vsync(vsync),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (x !== 10'd0) begin
            fails++; $display("FAIL reset_x: got %0d want 0", x);
        end
        checks++;
        if (y !== 10'd0) begin
            fails++; $display("FAIL reset_y: got %0d want 0", y);
        end
        checks++;
        if (p_tick !== 1'b0) begin
            fails++; $display("FAIL reset_p_tick: got %b want 0", p_tick);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            fails++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick);
        end
        checks++;
        if (video_on !== 1'b0) begin
            fails++; $display("FAIL reset_video_on: got %b want 0", video_on);
        end
        checks++;
        if (hsync !== 1'b1) begin
            fails++; $display("FAIL reset_hsync: got %b want 1", hsync);
        end
        checks++;
        if (vsync !== 1'b1) begin
            fails++; $display("FAIL reset_vsync: got %b want 1", vsync);
        end
        checks++;
        if (rgb_out !== 3'b000) begin
            fails++; $display("FAIL reset_rgb: got %b want 000", rgb_out);
        end
    endtask

    // Release on a falling edge; p_tick alternates, x advances every 2 clk.
    task automatic test_divider();
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (p_tick !== 1'((k % 2) == 1)) begin
                fails++;
                $display("FAIL div_p_tick[%0d]: got %b want %b", k, p_tick, (k % 2) == 1);
            end
            checks++;
            if (x !== 10'(k / 2)) begin
                fails++; $display("FAIL div_x[%0d]: got %0d want %0d", k, x, k / 2);
            end
            checks++;
            if (video_on !== 1'(k >= 2)) begin
                fails++;
                $display("FAIL div_video_on[%0d]: got %b want %b", k, video_on, k >= 2);
            end
        end
    endtask

    task automatic test_frame();
        int  n, cyc, maxx, maxy;
        int  vo_cnt, vo_run, vo_maxrun, vo_blank;
        int  hs_cnt, hs_first, vs_cnt, vs_fx, vs_fy;
        int  hold_err, blank_rgb, rgb_match, rgb_match_exp;
        int  px, py;
        logic pv, ph, pvs;
        logic [2:0] pr;
        bit  found, done;
        rgb_in = 3'b101;
        n = 0;
        found = 0;
        while (!found && n < 3 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
            if (frame_tick) found = 1;
        end
        checks++;
        if (!found) begin
            fails++; $display("FAIL frame_sync: frame_tick not seen in %0d clk", n);
            return;
        end
        checks++;
        if (x !== 10'(HT - 1) || y !== 10'(VT - 1) || p_tick !== 1'b1) begin
            fails++;
            $display("FAIL frame_tick_pos: got x=%0d y=%0d p=%b want %0d %0d 1",
                     x, y, p_tick, HT - 1, VT - 1);
        end
        px = int'(x); py = int'(y);
        pv = video_on; ph = hsync; pvs = vsync; pr = rgb_out;
        cyc = 0; done = 0; maxx = 0; maxy = 0;
        vo_cnt = 0; vo_run = 0; vo_maxrun = 0; vo_blank = 0;
        hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_fx = -1; vs_fy = -1;
        hold_err = 0; blank_rgb = 0; rgb_match = 0;
        while (!done && cyc < 2 * FRAME_CLKS) begin
            @(negedge clk);
            cyc++;
            if (p_tick) begin
                if (video_on !== pv || hsync !== ph ||
                    vsync !== pvs || rgb_out !== pr) hold_err++;
                if (int'(x) > maxx) maxx = int'(x);
                if (int'(y) > maxy) maxy = int'(y);
                if (video_on) begin
                    vo_cnt++;
                    vo_run++;
                    if (vo_run > vo_maxrun) vo_maxrun = vo_run;
                    if (py >= VD) vo_blank++;
                end else begin
                    vo_run = 0;
                end
                if (y == 10'd1 && !hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(x);
                end
                if (!vsync) begin
                    vs_cnt++;
                    if (vs_fx < 0) begin
                        vs_fx = int'(x); vs_fy = int'(y);
                    end
                end
                if (!video_on && rgb_out !== 3'b000) blank_rgb++;
                if (video_on && rgb_out === rgb_in) rgb_match++;
                px = int'(x); py = int'(y);
            end
            pv = video_on; ph = hsync; pvs = vsync; pr = rgb_out;
            if (frame_tick) done = 1;
        end
`ifdef VGA_RGB_BORDER_EN
        rgb_match_exp = HD * VD - (2 * HD + 2 * VD - 4);
`else
        rgb_match_exp = HD * VD;
`endif
        checks++;
        if (cyc != FRAME_CLKS) begin
            fails++; $display("FAIL frame_period: got %0d clk want %0d", cyc, FRAME_CLKS);
        end
        checks++;
        if (maxx != HT - 1) begin
            fails++; $display("FAIL x_max: got %0d want %0d", maxx, HT - 1);
        end
        checks++;
        if (maxy != VT - 1) begin
            fails++; $display("FAIL y_max: got %0d want %0d", maxy, VT - 1);
        end
        checks++;
        if (hs_cnt != HS) begin
            fails++; $display("FAIL hsync_width: got %0d want %0d", hs_cnt, HS);
        end
        checks++;
        if (hs_first != HD + HF + 1) begin
            fails++; $display("FAIL hsync_start: got x=%0d want %0d", hs_first, HD + HF + 1);
        end
        checks++;
        if (vs_cnt != VS * HT) begin
            fails++; $display("FAIL vsync_width: got %0d want %0d", vs_cnt, VS * HT);
        end
        checks++;
        if (vs_fx != 1 || vs_fy != VD + VF) begin
            fails++;
            $display("FAIL vsync_start: got (%0d,%0d) want (1,%0d)", vs_fx, vs_fy, VD + VF);
        end
        checks++;
        if (vo_cnt != HD * VD) begin
            fails++; $display("FAIL video_on_total: got %0d want %0d", vo_cnt, HD * VD);
        end
        checks++;
        if (vo_maxrun != HD) begin
            fails++; $display("FAIL video_on_run: got %0d want %0d", vo_maxrun, HD);
        end
        checks++;
        if (vo_blank != 0) begin
            fails++; $display("FAIL video_on_blank_lines: got %0d want 0", vo_blank);
        end
        checks++;
        if (blank_rgb != 0) begin
            fails++; $display("FAIL rgb_blanking: got %0d bad want 0", blank_rgb);
        end
        checks++;
        if (rgb_match != rgb_match_exp) begin
            fails++; $display("FAIL rgb_pass: got %0d want %0d", rgb_match, rgb_match_exp);
        end
        checks++;
        if (hold_err != 0) begin
            fails++; $display("FAIL output_hold: got %0d changes want 0", hold_err);
        end
    endtask

    // Waits until pixel (wx,wy) has been sampled, then to the next p_tick
    // sample where the output stage shows that pixel.
    task automatic wait_pixel(input int wx, input int wy, output bit ok);
        int n;
        n = 0;
        ok = 0;
        while (!ok && n < 3 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
            if (p_tick && int'(x) == wx && int'(y) == wy) ok = 1;
        end
        if (ok) begin
            ok = 0;
            n = 0;
            while (!ok && n < 4 * CLK_DIV) begin
                @(negedge clk);
                n++;
                if (p_tick) ok = 1;
            end
        end
    endtask

    task automatic test_rgb();
        bit ok;
`ifdef VGA_RGB_BORDER_EN
        int         tx[8] = '{0, HD - 1, 5, 5, 5, HD, 5, HD + HF + 1};
        int         ty[8] = '{5, 5, 0, VD - 1, 5, 5, VD, 5};
        logic [2:0] te[8] = '{3'b111, 3'b111, 3'b111, 3'b111,
                              3'b001, 3'b000, 3'b000, 3'b000};
        rgb_in = 3'b001;
`else
        int         tx[8] = '{5, 0, HD - 1, HD, HD + HF + 1, 5, 5, 5};
        int         ty[8] = '{5, 5, 5, 5, 5, VD - 1, VD, VD + VF};
        logic [2:0] te[8] = '{3'b101, 3'b101, 3'b101, 3'b000,
                              3'b000, 3'b101, 3'b000, 3'b000};
        rgb_in = 3'b101;
`endif
        for (int i = 0; i < 8; i++) begin
            wait_pixel(tx[i], ty[i], ok);
            checks++;
            if (!ok) begin
                fails++; $display("FAIL rgb_wait(%0d,%0d): pixel not reached", tx[i], ty[i]);
            end else if (rgb_out !== te[i]) begin
                fails++;
                $display("FAIL rgb_px(%0d,%0d): got %b want %b", tx[i], ty[i], rgb_out, te[i]);
            end
        end
        rgb_in = 3'b101;
    endtask

    task automatic test_async_reset();
        int n;
        bit found;
        n = 0;
        found = 0;
        while (!found && n < 3 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
            if (p_tick && x == 10'd10 && y == 10'd5) found = 1;
        end
        checks++;
        if (!found) begin
            fails++; $display("FAIL areset_wait: pixel (10,5) not reached");
            return;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (x !== 10'd0 || y !== 10'd0) begin
            fails++; $display("FAIL areset_xy: got (%0d,%0d) want (0,0)", x, y);
        end
        checks++;
        if (p_tick !== 1'b0 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL areset_ticks: got p=%b f=%b want 0 0", p_tick, frame_tick);
        end
        checks++;
        if (video_on !== 1'b0 || rgb_out !== 3'b000) begin
            fails++;
            $display("FAIL areset_video: got vo=%b rgb=%b want 0 000", video_on, rgb_out);
        end
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            fails++; $display("FAIL areset_sync: got hs=%b vs=%b want 1 1", hsync, vsync);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (x !== 10'd0 || p_tick !== 1'b1) begin
            fails++; $display("FAIL restart_first: got x=%0d p=%b want 0 1", x, p_tick);
        end
        @(negedge clk);
        checks++;
        if (x !== 10'd1 || y !== 10'd0) begin
            fails++; $display("FAIL restart_incr: got (%0d,%0d) want (1,0)", x, y);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_frame();
        test_rgb();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
